mem_access_stage: RTL and testbench



---
 rtl/mem_access_stage_pkg.sv | 13 +
 rtl/mem_align.sv | 36 +++
 rtl/mem_access_stage.sv | 109 ++++++++++
 tb/tb_mem_access_stage.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg: shared widths, access-width codes and FSM states for the MEM stage
package mem_access_stage_pkg;
  localparam int NB_DATA_DFLT = 32;
  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b11
  } width_e;
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;
endpackage

// File: rtl/mem_align.sv
// mem_align: store lane replication, byte enables, load extraction/extension, misalignment detection
module mem_align
  import mem_access_stage_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DFLT
) (
  input  logic [1:0]         i_width,
  input  logic               i_sign_flag,
  input  logic               i_read,
  input  logic               i_write,
  input  logic [1:0]         i_lane,
  input  logic [NB_DATA-1:0] i_wdata,
  input  logic [NB_DATA-1:0] i_rdata,
  output logic [3:0]         o_be,
  output logic [NB_DATA-1:0] o_wdata,
  output logic [NB_DATA-1:0] o_rdata,
  output logic               o_misaligned
);
  logic        w_byte;
  logic        w_half;
  logic [7:0]  w_b;
  logic [15:0] w_h;
  // width decode: the unused 10 code falls through to word
  assign w_byte = i_width == BYTE;
  assign w_half = i_width == HALF;
  // load lane extraction, little-endian
  assign w_b = i_rdata[{i_lane, 3'b000} +: 8];
  assign w_h = i_rdata[{i_lane[1], 4'b0000} +: 16];
  // loads always fetch the whole word; stores enable only the touched lanes
  assign o_be = i_read ? 4'hF : w_byte ? 4'b0001 << i_lane : w_half ? (i_lane[1] ? 4'hC : 4'h3) : 4'hF;
  assign o_wdata = w_byte ? {4{i_wdata[7:0]}} : w_half ? {2{i_wdata[15:0]}} : i_wdata;
  assign o_rdata = w_byte ? {{(NB_DATA-8){i_sign_flag & w_b[7]}}, w_b}
                 : w_half ? {{(NB_DATA-16){i_sign_flag & w_h[15]}}, w_h} : i_rdata;
  // simultaneous read+write is rejected through the same error path as misalignment
  assign o_misaligned = (i_read & i_write) | (w_half & i_lane[0]) | (~w_byte & ~w_half & |i_lane);
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: data-memory handshake FSM plus the MEM/WB pipeline register
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DFLT
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_halt,
  input  logic               i_mem2reg,
  input  logic               i_memRead,
  input  logic               i_memWrite,
  input  logic               i_regWrite,
  input  logic [1:0]         i_width,
  input  logic               i_sign_flag,
  input  logic [4:0]         i_write_reg,
  input  logic [NB_DATA-1:0] i_result,
  input  logic [NB_DATA-1:0] i_data4Mem,
  output logic               o_dm_req,
  output logic               o_dm_we,
  output logic [NB_DATA-1:0] o_dm_addr,
  output logic [3:0]         o_dm_be,
  output logic [NB_DATA-1:0] o_dm_wdata,
  input  logic               i_dm_ack,
  input  logic [NB_DATA-1:0] i_dm_rdata,
  output logic               o_stall,
  output logic               o_mem2reg,
  output logic               o_regWrite,
  output logic [4:0]         o_write_reg,
  output logic [NB_DATA-1:0] o_alu_result,
  output logic [NB_DATA-1:0] o_read_data,
  output logic               o_misaligned
);
  state_e             r_state;
  logic               r_mem2reg;
  logic               r_regWrite;
  logic [4:0]         r_write_reg;
  logic [NB_DATA-1:0] r_alu_result;
  logic [NB_DATA-1:0] r_read_data;
  logic               r_misaligned;
  logic               w_mis;
  logic               w_mem;
  logic               w_err;
  logic               w_wait;
  logic               w_frozen;
  logic [NB_DATA-1:0] w_ld;

  mem_align #(.NB_DATA(NB_DATA)) u_align (
    .i_width     (i_width),
    .i_sign_flag (i_sign_flag),
    .i_read      (i_memRead),
    .i_write     (i_memWrite),
    .i_lane      (i_result[1:0]),
    .i_wdata     (i_data4Mem),
    .i_rdata     (i_dm_rdata),
    .o_be        (o_dm_be),
    .o_wdata     (o_dm_wdata),
    .o_rdata     (w_ld),
    .o_misaligned(w_mis)
  );

  assign w_mem  = i_memRead | i_memWrite;
  assign w_err  = w_mem & w_mis;
  assign w_wait = r_state == WAIT;
  // halt only freezes once no access is in flight, so a WAIT always completes first
  assign w_frozen = i_halt & ~w_wait;
  // reset gates the request so it drops without waiting for the state flop
  assign o_dm_req  = i_rst_n & (w_wait | (~i_halt & w_mem & ~w_mis));
  assign o_dm_we   = o_dm_req & i_memWrite;
  assign o_dm_addr = {i_result[NB_DATA-1:2], 2'b00};
  assign o_stall   = o_dm_req & ~i_dm_ack;
  assign o_mem2reg    = r_mem2reg;
  assign o_regWrite   = r_regWrite;
  assign o_write_reg  = r_write_reg;
  assign o_alu_result = r_alu_result;
  assign o_read_data  = r_read_data;
  assign o_misaligned = r_misaligned;

  // handshake FSM: an unacknowledged request parks in WAIT until ack
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else r_state <= o_stall ? WAIT : IDLE;
  end

  // MEM/WB register: hold when frozen, bubble while stalled, otherwise capture the instruction
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem2reg    <= 1'b0;
      r_regWrite   <= 1'b0;
      r_write_reg  <= '0;
      r_alu_result <= '0;
      r_read_data  <= '0;
      r_misaligned <= 1'b0;
    end else if (w_frozen) begin
      r_misaligned <= 1'b0;
    end else if (o_stall) begin
      r_mem2reg    <= 1'b0;
      r_regWrite   <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_mem2reg    <= i_mem2reg;
      r_regWrite   <= i_regWrite & ~w_err;
      r_write_reg  <= i_write_reg;
      r_alu_result <= i_result;
      r_misaligned <= w_err;
      if (o_dm_req & i_memRead) r_read_data <= w_ld;
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed scenarios plus random traffic against a behavioural model
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_halt = 1'b0;
  logic        i_mem2reg = 1'b0, i_memRead = 1'b0, i_memWrite = 1'b0, i_regWrite = 1'b0;
  logic [1:0]  i_width = 2'b11;
  logic        i_sign_flag = 1'b0;
  logic [4:0]  i_write_reg = '0;
  logic [31:0] i_result = '0, i_data4Mem = '0;
  logic        o_dm_req, o_dm_we;
  logic [31:0] o_dm_addr, o_dm_wdata;
  logic [3:0]  o_dm_be;
  logic        i_dm_ack = 1'b0;
  logic [31:0] i_dm_rdata = '0;
  logic        o_stall, o_mem2reg, o_regWrite, o_misaligned;
  logic [4:0]  o_write_reg;
  logic [31:0] o_alu_result, o_read_data;
  int          n_chk = 0;
  int          n_bad = 0;
  logic [31:0] last_rd = '0;

  mem_access_stage #(.NB_DATA(32)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_halt(i_halt),
    .i_mem2reg(i_mem2reg), .i_memRead(i_memRead), .i_memWrite(i_memWrite), .i_regWrite(i_regWrite),
    .i_width(i_width), .i_sign_flag(i_sign_flag), .i_write_reg(i_write_reg),
    .i_result(i_result), .i_data4Mem(i_data4Mem),
    .o_dm_req(o_dm_req), .o_dm_we(o_dm_we), .o_dm_addr(o_dm_addr), .o_dm_be(o_dm_be),
    .o_dm_wdata(o_dm_wdata), .i_dm_ack(i_dm_ack), .i_dm_rdata(i_dm_rdata),
    .o_stall(o_stall), .o_mem2reg(o_mem2reg), .o_regWrite(o_regWrite), .o_write_reg(o_write_reg),
    .o_alu_result(o_alu_result), .o_read_data(o_read_data), .o_misaligned(o_misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit m_mis(input bit rd, input bit wr, input logic [1:0] w, input logic [31:0] a);
    int sz = (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
    return (rd && wr) || (a % sz != 0);
  endfunction

  function automatic logic [3:0] m_be(input bit rd, input logic [1:0] w, input logic [31:0] a);
    if (rd || w[1]) return 4'hF;
    if (w == 2'b00) return 4'(1 << (a % 4));
    return 4'(3 << (a & 2));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] w, input logic [31:0] d);
    if (w == 2'b00) return (d & 32'hFF) * 32'h0101_0101;
    if (w == 2'b01) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] w, input bit sg, input logic [31:0] a, input logic [31:0] r);
    logic [31:0] v;
    if (w == 2'b00) begin
      v = (r >> (8 * (a % 4))) & 32'hFF;
      if (sg && v >= 128) v = v - 256;
    end else if (w == 2'b01) begin
      v = (r >> (8 * (a & 2))) & 32'hFFFF;
      if (sg && v >= 32768) v = v - 65536;
    end else v = r;
    return v;
  endfunction

  // one instruction held until it retires; dly = wait cycles before ack
  task automatic do_instr(input bit rd, input bit wr, input logic [1:0] w, input bit sg,
                          input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdata,
                          input int dly, input bit rw, input bit m2r, input logic [4:0] wreg);
    bit mem = rd || wr;
    bit mis = mem && m_mis(rd, wr, w, a);
    bit pend = mem && !mis;
    @(negedge clk);
    i_memRead = rd; i_memWrite = wr; i_width = w; i_sign_flag = sg; i_result = a;
    i_data4Mem = d; i_regWrite = rw; i_mem2reg = m2r; i_write_reg = wreg;
    i_dm_ack = pend && dly == 0;
    i_dm_rdata = i_dm_ack ? rdata : $urandom;
    #1;
    chk("req", o_dm_req, pend);
    chk("stall", o_stall, pend && dly > 0);
    if (pend) begin
      chk("addr", o_dm_addr, a & 32'hFFFF_FFFC);
      chk("be", o_dm_be, m_be(rd, w, a));
      chk("we", o_dm_we, wr);
      if (wr) chk("wdata", o_dm_wdata, m_wdata(w, d));
      for (int i = 0; i < dly; i++) begin
        @(posedge clk); #1;
        chk("bubble_rw", o_regWrite, 0);
        chk("bubble_m2r", o_mem2reg, 0);
        @(negedge clk);
        i_dm_ack = i == dly - 1;
        i_dm_rdata = i_dm_ack ? rdata : $urandom;
        #1;
        chk("wait_req", o_dm_req, 1);
        chk("wait_be", o_dm_be, m_be(rd, w, a));
        chk("wait_stall", o_stall, i != dly - 1);
      end
    end
    @(posedge clk); #1;
    chk("rw", o_regWrite, rw && !mis);
    chk("m2r", o_mem2reg, m2r);
    chk("mis", o_misaligned, mis);
    chk("alu", o_alu_result, a);
    chk("wreg", o_write_reg, wreg);
    if (pend && rd) last_rd = m_load(w, sg, a, rdata);
    chk("rdata", o_read_data, last_rd);
  endtask

  initial begin
    #1;
    chk("rst_rw", o_regWrite, 0);
    chk("rst_alu", o_alu_result, 0);
    chk("rst_rd", o_read_data, 0);
    chk("rst_req", o_dm_req, 0);
    @(negedge clk); i_rst_n = 1'b1;
    // store byte, immediate ack
    do_instr(0, 1, 2'b00, 0, 32'h13, 32'hA5, 0, 0, 0, 0, 5'd0);
    chk("s1_addr_be", {o_dm_be, 28'h0}, {4'b1000, 28'h0});
    // signed half load, three wait cycles
    do_instr(1, 0, 2'b01, 1, 32'h22, 0, 32'h8001_7FFF, 3, 1, 1, 5'd7);
    chk("s2_rdata", o_read_data, 32'hFFFF_8001);
    // unsigned byte load
    do_instr(1, 0, 2'b00, 0, 32'h07, 0, 32'hF000_0000, 1, 1, 1, 5'd3);
    chk("s3_rdata", o_read_data, 32'h0000_00F0);
    // misaligned word store, then the pulse must end
    do_instr(0, 1, 2'b11, 0, 32'h06, 32'h1111_2222, 0, 0, 1, 0, 5'd4);
    do_instr(0, 0, 2'b11, 0, 32'h99, 0, 0, 0, 1, 0, 5'd5);
    do_instr(1, 1, 2'b11, 0, 32'h40, 0, 0, 0, 1, 0, 5'd6);
    // reset while waiting
    @(negedge clk);
    i_memRead = 1; i_memWrite = 0; i_width = 2'b11; i_result = 32'h100; i_dm_ack = 0; i_regWrite = 1;
    @(posedge clk); #1;
    chk("s5_wait_stall", o_stall, 1);
    @(negedge clk); i_rst_n = 1'b0; #1;
    chk("s5_req", o_dm_req, 0);
    chk("s5_stall", o_stall, 0);
    chk("s5_rw", o_regWrite, 0);
    chk("s5_rd", o_read_data, 0);
    chk("s5_alu", o_alu_result, 0);
    chk("s5_wreg", o_write_reg, 0);
    last_rd = 0;
    i_memRead = 0;
    @(negedge clk); i_rst_n = 1'b1;
    do_instr(0, 0, 2'b11, 0, 32'h1234, 0, 0, 0, 1, 0, 5'd9);
    // halt raised during WAIT
    @(negedge clk);
    i_memRead = 1; i_memWrite = 0; i_width = 2'b11; i_result = 32'h200; i_regWrite = 1;
    i_mem2reg = 1; i_write_reg = 5'd12; i_dm_ack = 0;
    @(negedge clk); i_halt = 1; #1;
    chk("s6_req_halt", o_dm_req, 1);
    @(negedge clk); i_dm_ack = 1; i_dm_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk("s6_rdata", o_read_data, 32'hDEAD_BEEF);
    chk("s6_rw", o_regWrite, 1);
    @(negedge clk);
    i_dm_ack = 0; i_result = 32'h300; i_write_reg = 5'd1; i_regWrite = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("s6_hold_req", o_dm_req, 0);
      chk("s6_hold_rd", o_read_data, 32'hDEAD_BEEF);
      chk("s6_hold_rw", o_regWrite, 1);
      chk("s6_hold_alu", o_alu_result, 32'h200);
    end
    @(negedge clk); i_halt = 0;
    last_rd = 32'hDEAD_BEEF;
    // random traffic
    for (int n = 0; n < 300; n++) begin
      int k = $urandom_range(0, 3);
      do_instr(k == 1 || k == 3 && $urandom_range(0, 3) == 0, k == 2 || k == 3,
               2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
               $urandom_range(0, 3), 1'($urandom), 1'($urandom), 5'($urandom));
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
